// File: rtl/btb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btb_pkg : shared widths, update record and FSM state for btb_ctrl |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package btb_pkg;

  localparam int BTB_IDX_W = 8;
  localparam int BTB_TAG_W = 24;

  typedef struct packed {
    logic [BTB_IDX_W-1:0] idx;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic                 valid;
  } btb_upd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } btb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb_upd_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btb_upd_fifo : small FIFO of pending BTB table updates            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  btb_upd_t din,
  output btb_upd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  btb_upd_t       mem_q [QDEPTH];
  btb_upd_t       mem_d [QDEPTH];
  logic [PW:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]    rd_ptr_q, rd_ptr_d;

  // Extra pointer bit distinguishes full from empty when the slot bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign dout  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[PW-1:0]] = din;
        wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/btb_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btb_ctrl : BTB update/redirect controller with invalidate sweep   |
// | Optional statistics counters: define BTB_CTRL_STATS_EN            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int IDX_W  = BTB_IDX_W,
  parameter int TAG_W  = BTB_TAG_W,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resolve_E,
  input  logic              taken_E,
  input  logic [TAG_W-1:0]  pc_E,
  input  logic [31:0]       target_E,
  input  logic              pred_hit_E,
  input  logic [31:0]       pred_target_E,
  input  logic              flush_req,
  input  logic              tbl_wr_ready,
  output logic              tbl_wr_en,
  output logic [IDX_W-1:0]  tbl_wr_idx,
  output logic [TAG_W-1:0]  tbl_wr_tag,
  output logic [31:0]       tbl_wr_target,
  output logic              tbl_wr_valid,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush_busy,
  output logic              flush_done,
  output logic [15:0]       stat_mispred,
  output logic [15:0]       stat_drop
);

  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;

  logic     mispred, in_idle;
  logic     q_push, q_pop, q_full, q_empty;
  btb_upd_t upd_in, q_head;

  assign mispred = resolve_E &
                   ((taken_E & (~pred_hit_E | (pred_target_E != target_E))) |
                    (~taken_E & pred_hit_E));
  assign in_idle = (state_q == ST_IDLE);

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign q_pop  = in_idle & ~q_empty & tbl_wr_ready;
  assign q_push = mispred & in_idle & ~flush_req & (~q_full | q_pop);

  always_comb begin
    upd_in.idx    = BTB_IDX_W'(pc_E[IDX_W-1:0]);
    upd_in.tag    = BTB_TAG_W'(pc_E);
    upd_in.target = taken_E ? target_E : 32'd0;
    upd_in.valid  = taken_E;
  end

  btb_upd_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_req),
    .push  (q_push),
    .pop   (q_pop),
    .din   (upd_in),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Sweep writes are held off while reset is asserted even though state is SWEEP.
  always_comb begin
    tbl_wr_en     = 1'b0;
    tbl_wr_idx    = IDX_W'(q_head.idx);
    tbl_wr_tag    = TAG_W'(q_head.tag);
    tbl_wr_target = q_head.target;
    tbl_wr_valid  = q_head.valid;
    case (state_q)
      ST_IDLE: tbl_wr_en = q_pop;
      ST_SWEEP: begin
        tbl_wr_en     = tbl_wr_ready & rst_n;
        tbl_wr_idx    = cnt_q;
        tbl_wr_tag    = '0;
        tbl_wr_target = 32'd0;
        tbl_wr_valid  = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = mispred;
    redirect_pc_d    = redirect_pc_q;
    if (mispred) begin
      redirect_pc_d = taken_E ? target_E : (32'(pc_E) + 32'd4);
    end
    if (flush_req) begin
      state_d = ST_SWEEP;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          if (tbl_wr_ready) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (&cnt_q) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_SWEEP;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_busy     = (state_q != ST_IDLE);
  assign flush_done     = (state_q == ST_DONE);

`ifdef BTB_CTRL_STATS_EN
  logic [15:0] stat_mispred_q, stat_mispred_d;
  logic [15:0] stat_drop_q, stat_drop_d;
  logic        q_drop;

  // Discards during a sweep or alongside flush_req are not drops.
  assign q_drop = mispred & in_idle & ~flush_req & q_full & ~q_pop;

  always_comb begin
    stat_mispred_d = mispred ? sat_inc16(stat_mispred_q) : stat_mispred_q;
    stat_drop_d    = q_drop  ? sat_inc16(stat_drop_q)    : stat_drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_mispred_q <= 16'd0;
      stat_drop_q    <= 16'd0;
    end else begin
      stat_mispred_q <= stat_mispred_d;
      stat_drop_q    <= stat_drop_d;
    end
  end

  assign stat_mispred = stat_mispred_q;
  assign stat_drop    = stat_drop_q;
`else
  assign stat_mispred = 16'd0;
  assign stat_drop    = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_btb_ctrl : self-checking bench for btb_ctrl (BTB_CTRL_STATS_EN)|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_btb_ctrl;

  localparam int IDX_W  = 8;
  localparam int TAG_W  = 24;
  localparam int QD     = 2;
  localparam int NENT   = 1 << IDX_W;

  logic              clk, rst_n;
  logic              resolve_E, taken_E, pred_hit_E, flush_req, tbl_wr_ready;
  logic [TAG_W-1:0]  pc_E;
  logic [31:0]       target_E, pred_target_E;
  logic              tbl_wr_en, tbl_wr_valid, redirect_valid, flush_busy, flush_done;
  logic [IDX_W-1:0]  tbl_wr_idx;
  logic [TAG_W-1:0]  tbl_wr_tag;
  logic [31:0]       tbl_wr_target, redirect_pc;
  logic [15:0]       stat_mispred, stat_drop;

  btb_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n),
    .resolve_E(resolve_E), .taken_E(taken_E), .pc_E(pc_E), .target_E(target_E),
    .pred_hit_E(pred_hit_E), .pred_target_E(pred_target_E),
    .flush_req(flush_req), .tbl_wr_ready(tbl_wr_ready),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_tag(tbl_wr_tag),
    .tbl_wr_target(tbl_wr_target), .tbl_wr_valid(tbl_wr_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_busy(flush_busy), .flush_done(flush_done),
    .stat_mispred(stat_mispred), .stat_drop(stat_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned idx;
    int unsigned tag;
    int unsigned target;
    bit          valid;
  } ent_t;

  ent_t        mq[$];
  int          m_mode;      // 0 normal, 1 sweeping, 2 sweep just finished
  int unsigned m_idx;
  bit          m_rv;
  int unsigned m_rpc;
  int unsigned m_mis, m_drop;

  task automatic model_reset();
    mq.delete();
    m_mode = 1; m_idx = 0; m_rv = 0; m_rpc = 0; m_mis = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit   wrong, pop, was_normal;
    ent_t e;
    if (!resolve_E)        wrong = 0;
    else if (taken_E)      wrong = !pred_hit_E || (pred_target_E != target_E);
    else                   wrong = pred_hit_E;
    m_rv = wrong;
    if (wrong) begin
      m_rpc = taken_E ? target_E : ({8'h0, pc_E} + 32'd4);
      if (m_mis < 16'hFFFF) m_mis++;
    end
    was_normal = (m_mode == 0);
    pop = was_normal && (mq.size() > 0) && tbl_wr_ready;
    if (flush_req) begin
      mq.delete();
      m_mode = 1;
      m_idx  = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (wrong && was_normal) begin
        e.idx    = {8'h0, pc_E} % NENT;
        e.tag    = {8'h0, pc_E};
        e.target = taken_E ? target_E : 0;
        e.valid  = taken_E;
        if (mq.size() < QD) mq.push_back(e);
        else if (m_drop < 16'hFFFF) m_drop++;
      end
      if (m_mode == 1 && tbl_wr_ready) begin
        if (m_idx == NENT - 1) m_mode = 2;
        else m_idx++;
      end else if (m_mode == 2) begin
        m_mode = 0;
      end
    end
  endtask

  task automatic model_check();
    bit          e_en;
    int unsigned e_mis, e_drop;
`ifdef BTB_CTRL_STATS_EN
    e_mis = m_mis; e_drop = m_drop;
`else
    e_mis = 0; e_drop = 0;
`endif
    if (!rst_n)            e_en = 0;
    else if (m_mode == 1)  e_en = tbl_wr_ready;
    else if (m_mode == 0)  e_en = tbl_wr_ready && (mq.size() > 0);
    else                   e_en = 0;
    chk("wr_en", 32'(tbl_wr_en), 32'(e_en));
    if (e_en && m_mode == 1) begin
      chk("sweep_idx", 32'(tbl_wr_idx), m_idx);
      chk("sweep_valid", 32'(tbl_wr_valid), 0);
    end else if (e_en) begin
      chk("upd_idx", 32'(tbl_wr_idx), mq[0].idx);
      chk("upd_tag", 32'(tbl_wr_tag), mq[0].tag);
      chk("upd_target", tbl_wr_target, mq[0].target);
      chk("upd_valid", 32'(tbl_wr_valid), 32'(mq[0].valid));
    end
    chk("flush_busy", 32'(flush_busy), 32'(m_mode != 0));
    chk("flush_done", 32'(flush_done), 32'(m_mode == 2));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("stat_mispred", 32'(stat_mispred), e_mis);
    chk("stat_drop", 32'(stat_drop), e_drop);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) model_reset();
      model_check();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_in();
    resolve_E = 0; taken_E = 0; pred_hit_E = 0; flush_req = 0;
    pc_E = '0; target_E = 0; pred_target_E = 0;
  endtask

  task automatic resolve(input bit tk, input bit hit, input logic [TAG_W-1:0] pc,
                         input logic [31:0] tgt, input logic [31:0] ptgt);
    resolve_E = 1; taken_E = tk; pred_hit_E = hit; pc_E = pc;
    target_E = tgt; pred_target_E = ptgt;
  endtask

  // Called at negedge+3; the current cycle counts as cycle 1.
  task automatic wait_sweep(output int k_done, output int n_wr);
    k_done = 0; n_wr = 0;
    for (int k = 1; k <= 400; k++) begin
      if (tbl_wr_en && !tbl_wr_valid) n_wr++;
      if (flush_done) begin
        k_done = k;
        break;
      end
      @(negedge clk); #3;
    end
  endtask

  task automatic step();
    @(negedge clk); idle_in(); #3;
  endtask

  int kd, nw, exp_mis, exp_drop;

  initial begin
    rst_n = 0; tbl_wr_ready = 1; idle_in();
    repeat (2) @(negedge clk);
    #3;
    chk("rst_busy", 32'(flush_busy), 1);
    chk("rst_wr_en", 32'(tbl_wr_en), 0);
    chk("rst_redirect", 32'(redirect_valid), 0);
    chk("rst_done", 32'(flush_done), 0);

    // Reset-release sweep: 256 invalidates then flush_done on cycle 257.
    @(negedge clk); rst_n = 1; #3;
    chk("sweep_first_idx", 32'(tbl_wr_idx), 0);
    wait_sweep(kd, nw);
    chk("sweep_done_cycle", kd, 257);
    chk("sweep_writes", nw, 256);
    step();
    chk("busy_after_done", 32'(flush_busy), 0);

    // Taken branch missed at fetch.
    @(negedge clk); resolve(1, 0, 24'h000104, 32'h200, 32'h0);
    step();
    chk("r1_rv", 32'(redirect_valid), 1);
    chk("r1_pc", redirect_pc, 32'h200);
    chk("r1_en", 32'(tbl_wr_en), 1);
    chk("r1_idx", 32'(tbl_wr_idx), 32'h04);
    chk("r1_tag", 32'(tbl_wr_tag), 32'h000104);
    chk("r1_valid", 32'(tbl_wr_valid), 1);
    chk("r1_target", tbl_wr_target, 32'h200);

    // Predicted taken but fell through.
    @(negedge clk); resolve(0, 1, 24'h000108, 32'h0, 32'h300);
    step();
    chk("r2_pc", redirect_pc, 32'h10C);
    chk("r2_idx", 32'(tbl_wr_idx), 32'h08);
    chk("r2_valid", 32'(tbl_wr_valid), 0);
    chk("r2_target", tbl_wr_target, 32'h0);

    // Correct prediction: no redirect, no update.
    @(negedge clk); resolve(1, 1, 24'h000110, 32'h500, 32'h500);
    step();
    chk("ok_rv", 32'(redirect_valid), 0);
    chk("ok_en", 32'(tbl_wr_en), 0);

    // Back-pressure: two queued, third dropped, then ordered drain.
    tbl_wr_ready = 0;
    @(negedge clk); resolve(1, 0, 24'h000010, 32'h1010, 32'h0);
    @(negedge clk); resolve(1, 0, 24'h000020, 32'h1020, 32'h0);
    @(negedge clk); resolve(1, 0, 24'h000030, 32'h1030, 32'h0);
    step();
`ifdef BTB_CTRL_STATS_EN
    exp_mis = 5; exp_drop = 1;
`else
    exp_mis = 0; exp_drop = 0;
`endif
    chk("bp_drop", 32'(stat_drop), exp_drop);
    chk("bp_mispred", 32'(stat_mispred), exp_mis);
    chk("bp_hold", 32'(tbl_wr_en), 0);
    @(negedge clk); tbl_wr_ready = 1; #3;
    chk("drain0_idx", 32'(tbl_wr_idx), 32'h10);
    chk("drain0_tgt", tbl_wr_target, 32'h1010);
    step();
    chk("drain1_idx", 32'(tbl_wr_idx), 32'h20);
    step();
    chk("drain_empty", 32'(tbl_wr_en), 0);

    // Flush with a queued entry, then re-flush at sweep index 100.
    tbl_wr_ready = 0;
    @(negedge clk); resolve(1, 0, 24'h000050, 32'h2050, 32'h0);
    @(negedge clk); idle_in(); flush_req = 1;
    @(negedge clk); idle_in(); tbl_wr_ready = 1;
    for (int k = 0; k < 200; k++) begin
      #3;
      if (tbl_wr_idx == 8'd99) break;
      @(negedge clk);
    end
    chk("reach_99", 32'(tbl_wr_idx), 99);
    @(negedge clk); flush_req = 1; resolve(1, 0, 24'h000040, 32'h444, 32'h0); #3;
    chk("at_100", 32'(tbl_wr_idx), 100);
    step();
    chk("restart_idx", 32'(tbl_wr_idx), 0);
    chk("sweep_redirect", redirect_pc, 32'h444);
    wait_sweep(kd, nw);
    chk("reflush_done_cycle", kd, 257);
    step();
    chk("reflush_queue_empty", 32'(tbl_wr_en), 0);
    chk("reflush_no_done", 32'(flush_done), 0);

    // Reset in the middle of a sweep restarts it from zero.
    @(negedge clk); flush_req = 1;
    @(negedge clk); idle_in();
    repeat (30) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; #3;
    chk("rst_mid_idx", 32'(tbl_wr_idx), 0);
    wait_sweep(kd, nw);
    chk("rst_mid_done_cycle", kd, 257);
    step();
    chk("rst_mid_idle", 32'(flush_busy), 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb_ctrl.md
BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 8, meaning BTB index width (2^IDX_W entries).
REQ-002 SHALL have parameter TAG_W, default 24, meaning stored PC tag width.
REQ-003 SHALL have parameter QDEPTH, default 2, meaning update-queue depth (power of 2, >=2).
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- resolve_E  in  1  branch/jump resolved in E this cycle
- taken_E  in  1  actual outcome
- pc_E  in  TAG_W  PC of resolved instruction
- target_E  in  32  actual target
- pred_hit_E  in  1  BTB hit recorded at fetch
- pred_target_E  in  32  predicted target recorded at fetch
- flush_req  in  1  request full BTB invalidate (fence.i/CSR)
- tbl_wr_ready  in  1  table write port free
- tbl_wr_en  out  1  table write strobe
- tbl_wr_idx  out  IDX_W  write index
- tbl_wr_tag  out  TAG_W  write tag
- tbl_wr_target  out  32  write target
- tbl_wr_valid  out  1  valid bit written
- redirect_valid  out  1  mispredict redirect, one-cycle pulse
- redirect_pc  out  32  correct next PC
- flush_busy  out  1  sweep in progress
- flush_done  out  1  sweep complete, one-cycle pulse
- stat_mispred  out  16  mispredict count
- stat_drop  out  16  dropped-update count

Function
REQ-006 Mispredict SHALL be: resolve_E & ((taken_E & (!pred_hit_E | pred_target_E != target_E)) | (!taken_E & pred_hit_E)).
REQ-007 redirect_valid/redirect_pc SHALL be registered, asserted the cycle after mispredict; redirect_pc = taken_E ? target_E : pc_E+4 (mod 2^32, pc_E zero-extended).
REQ-008 Mispredict with taken_E SHALL enqueue {idx=pc_E[IDX_W-1:0], tag=pc_E, target=target_E, valid=1}; with !taken_E SHALL enqueue the same with valid=0, target=0.
REQ-009 Correct predictions SHALL NOT enqueue.
REQ-010 Queue SHALL be FIFO order; head drives tbl_wr_*; tbl_wr_en = queue non-empty & tbl_wr_ready & state IDLE; head pops when tbl_wr_en.
REQ-011 Enqueue when full SHALL be accepted only if a pop occurs the same cycle; otherwise dropped and stat_drop incremented.
REQ-012 FSM states IDLE, SWEEP, DONE: IDLE->SWEEP on flush_req; SWEEP writes index cnt with tbl_wr_valid=0 when tbl_wr_ready, cnt increments per accepted write; after index 2^IDX_W-1 accepted ->DONE; DONE->IDLE after one cycle pulsing flush_done.
REQ-013 flush_busy SHALL be 1 in SWEEP and DONE.
REQ-014 flush_req in any state SHALL clear the queue; flush_req in SWEEP/DONE SHALL restart the sweep at index 0.
REQ-015 Enqueues during SWEEP/DONE, or coincident with flush_req, SHALL be discarded without counting as drops; redirects still issue.
REQ-016 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-017 On rst_n low: state=SWEEP, cnt=0, queue empty, redirect_valid=0, redirect_pc=0, flush_done=0, flush_busy=1, tbl_wr_en=0, counters=0.
REQ-018 Reset mid-sweep SHALL restart the sweep from 0 on release; no flush_done for the aborted sweep.

Configuration
REQ-019 Macro BTB_CTRL_STATS_EN: defined -> stat_mispred counts mispredicts, stat_drop counts drops; undefined -> both outputs constant 0, no counter flops.

Structure
REQ-020 Package btb_pkg SHALL hold IDX_W/TAG_W defaults, btb_upd_t (idx, tag, target, valid) and FSM state enum.
REQ-021 Queue SHALL be sub-module btb_upd_fifo (QDEPTH, btb_upd_t payload, push/pop/full/empty).

Verification
REQ-022 Reset release, tbl_wr_ready=1 -> 256 writes idx 0..255 valid=0, flush_done on cycle 257, flush_busy then 0.
REQ-023 resolve_E, taken_E=1, pred_hit_E=0, pc_E=0x000104, target_E=0x200 -> next cycle redirect_pc=0x200; write idx 0x04 tag 0x000104 valid=1.
REQ-024 resolve_E, taken_E=0, pred_hit_E=1, pc_E=0x000108 -> redirect_pc=0x10C; invalidate write idx 0x08.
REQ-025 tbl_wr_ready=0, three consecutive mispredicts -> two queued, third dropped, stat_drop=1; raising ready drains in order.
REQ-026 flush_req at sweep index 100 with queue holding 1 entry -> queue cleared, sweep restarts at 0, single flush_done at end.
